// File: rtl/dist_filter_pkg.sv
// ---------------------------------------------------------------------------
// dist_pkg
// Shared definitions for the ultrasonic distance filter slice.
// Contents:
//   state_t     - filter FSM state encoding
//   US_PER_CM   - echo microseconds per centimetre of distance
//   DIV_ITER    - iterations of the sequential divider (one quotient bit each)
//   DIST_W      - width of the filtered distance output in cm
//   MEAS_W      - width of the raw echo width from the echo timer in us
// ---------------------------------------------------------------------------
package dist_pkg;

  localparam int US_PER_CM = 58;
  localparam int DIV_ITER  = 16;
  localparam int DIST_W    = 10;
  localparam int MEAS_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_UPDATE = 3'd2,
    ST_DIVIDE = 3'd3,
    ST_OUT    = 3'd4
  } state_t;

endpackage

// File: rtl/dist_filter_div.sv
// ---------------------------------------------------------------------------
// seq_div16
// Restoring divider by a constant, one quotient bit per clock.
// The first iteration is performed on the same edge that samples i_start,
// working directly on i_dividend, so the full quotient is in o_quotient and
// o_done pulses exactly DIV_ITER cycles after the cycle i_start was high.
// Ports:
//   clk_1mhz    in   block clock
//   nrst        in   asynchronous active-low reset, aborts a divide in flight
//   i_start     in   single-cycle start strobe
//   i_dividend  in   MEAS_W-bit dividend, sampled with i_start
//   o_quotient  out  MEAS_W-bit truncated quotient, valid while o_done is high
//                    and held until the next start
//   o_done      out  single-cycle completion strobe
// ---------------------------------------------------------------------------
module seq_div16
  import dist_pkg::*;
#(
  parameter int DIVISOR = US_PER_CM
)
(
  input  logic              clk_1mhz,
  input  logic              nrst,
  input  logic              i_start,
  input  logic [MEAS_W-1:0] i_dividend,
  output logic [MEAS_W-1:0] o_quotient,
  output logic              o_done
);

  // Partial remainders stay below DIVISOR, so this width always suffices.
  localparam int REM_W = $clog2(DIVISOR) + 1;
  localparam int CNT_W = $clog2(DIV_ITER + 1);
  localparam logic [REM_W:0]   DIV_V  = DIVISOR[REM_W:0];
  localparam logic [CNT_W-1:0] LAST_V = CNT_W'(DIV_ITER - 1);

  logic [REM_W-1:0]  r_rem;
  logic [MEAS_W-1:0] r_quo;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_run;
  logic              r_done;

  logic [REM_W-1:0]  w_rem_src;
  logic [MEAS_W-1:0] w_quo_src;
  logic [REM_W:0]    w_shift;
  logic [REM_W:0]    w_rem_nxt;
  logic              w_ge;

  // One restoring step. r_quo doubles as the dividend shift register: its MSB
  // feeds the remainder and the new quotient bit enters at the LSB.
  always_comb begin
    w_rem_src = i_start ? '0 : r_rem;
    w_quo_src = i_start ? i_dividend : r_quo;
    w_shift   = {w_rem_src, w_quo_src[MEAS_W-1]};
    w_ge      = (w_shift >= DIV_V);
    w_rem_nxt = w_ge ? (w_shift - DIV_V) : w_shift;
  end

  // A start always restarts the divide; otherwise iterate while running.
  always_ff @(posedge clk_1mhz or negedge nrst) begin
    if (!nrst) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_rem <= w_rem_nxt[REM_W-1:0];
        r_quo <= {w_quo_src[MEAS_W-2:0], w_ge};
        r_cnt <= CNT_W'(1);
        r_run <= 1'b1;
      end else if (r_run) begin
        r_rem <= w_rem_nxt[REM_W-1:0];
        r_quo <= {w_quo_src[MEAS_W-2:0], w_ge};
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == LAST_V) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_quotient = r_quo;
  assign o_done     = r_done;

endmodule

// File: rtl/dist_filter.sv
// ---------------------------------------------------------------------------
// dist_filter
// Validates raw echo widths, keeps a moving average over 2^AVG_LOG2 accepted
// samples, converts the average to centimetres and drives a proximity alarm.
// Optional feature: define DIST_FILTER_ALARM_EN to build the hysteresis alarm;
// without it the alarm port is tied low.
// Ports:
//   clk_1mhz    in   1 MHz block clock
//   nrst        in   asynchronous active-low reset
//   meas_valid  in   single-cycle strobe, new raw measurement present
//   meas_us     in   raw echo width in us
//   meas_ovf    in   echo timer overflowed (qualified by meas_valid)
//   dist_cm     out  filtered distance in cm, held between updates
//   dist_valid  out  single-cycle strobe, dist_cm just updated
//   busy        out  high while a measurement is being processed
//   alarm       out  proximity alarm with hysteresis
//   rej_cnt     out  saturating count of rejected measurements
// ---------------------------------------------------------------------------
module dist_filter
  import dist_pkg::*;
#(
  parameter int AVG_LOG2     = 2,
  parameter int MIN_US       = 116,
  parameter int MAX_US       = 23200,
  parameter int ALARM_ON_CM  = 20,
  parameter int ALARM_OFF_CM = 25
)
(
  input  logic              clk_1mhz,
  input  logic              nrst,
  input  logic              meas_valid,
  input  logic [MEAS_W-1:0] meas_us,
  input  logic              meas_ovf,
  output logic [DIST_W-1:0] dist_cm,
  output logic              dist_valid,
  output logic              busy,
  output logic              alarm,
  output logic [7:0]        rej_cnt
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = MEAS_W + AVG_LOG2;
  localparam logic [MEAS_W-1:0] MIN_V = MEAS_W'(MIN_US);
  localparam logic [MEAS_W-1:0] MAX_V = MEAS_W'(MAX_US);

  // The clear threshold must sit above the set threshold or the alarm chatters.
  if (ALARM_OFF_CM <= ALARM_ON_CM) begin : g_bad_thresholds
    $error("dist_filter: ALARM_OFF_CM must be greater than ALARM_ON_CM");
  end

  state_t            r_state;
  logic [MEAS_W-1:0] r_meas;
  logic              r_ovf;
  logic [MEAS_W-1:0] r_ring [DEPTH];
  logic [AVG_LOG2-1:0] r_ptr;
  logic              r_primed;
  logic [SUM_W-1:0]  r_sum;
  logic [DIST_W-1:0] r_dist_cm;
  logic              r_dist_valid;
  logic [7:0]        r_rej_cnt;

  logic              w_reject;
  logic [SUM_W-1:0]  w_sum_next;
  logic              w_div_start;
  logic [MEAS_W-1:0] w_div_q;
  logic              w_div_done;
  logic [DIST_W-1:0] w_dist_new;

  // Sample qualification and the running sum. Before the first accepted
  // sample the ring is considered full of that sample, hence sample<<AVG_LOG2.
  always_comb begin
    w_reject = r_ovf || (r_meas < MIN_V) || (r_meas > MAX_V);
    if (r_primed) begin
      w_sum_next = r_sum + SUM_W'(r_meas) - SUM_W'(r_ring[r_ptr]);
    end else begin
      w_sum_next = {r_meas, {AVG_LOG2{1'b0}}};
    end
  end

  // The divider starts from the freshly computed sum while still in ST_UPDATE,
  // which saves a cycle and lands dist_valid 19 edges after acceptance.
  assign w_div_start = (r_state == ST_UPDATE);

  seq_div16 #(
    .DIVISOR (US_PER_CM)
  ) u_div (
    .clk_1mhz   (clk_1mhz),
    .nrst       (nrst),
    .i_start    (w_div_start),
    .i_dividend (w_sum_next[SUM_W-1:AVG_LOG2]),
    .o_quotient (w_div_q),
    .o_done     (w_div_done)
  );

  // Clip the quotient to the output width.
  assign w_dist_new = (|w_div_q[MEAS_W-1:DIST_W]) ? {DIST_W{1'b1}} : w_div_q[DIST_W-1:0];

  // Ring storage carries no reset; the primed flag decides whether it is used.
  always_ff @(posedge clk_1mhz) begin
    if (r_state == ST_UPDATE) begin
      if (!r_primed) begin
        for (int i = 0; i < DEPTH; i++) begin
          r_ring[i] <= r_meas;
        end
      end else begin
        r_ring[r_ptr] <= r_meas;
      end
    end
  end

  // Main filter FSM. New strobes are only looked at in ST_IDLE, so anything
  // arriving while busy is dropped without touching the latch or rej_cnt.
  always_ff @(posedge clk_1mhz or negedge nrst) begin
    if (!nrst) begin
      r_state      <= ST_IDLE;
      r_meas       <= '0;
      r_ovf        <= 1'b0;
      r_ptr        <= '0;
      r_primed     <= 1'b0;
      r_sum        <= '0;
      r_dist_cm    <= '0;
      r_dist_valid <= 1'b0;
      r_rej_cnt    <= '0;
    end else begin
      r_dist_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (meas_valid) begin
            r_meas  <= meas_us;
            r_ovf   <= meas_ovf;
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (w_reject) begin
            if (r_rej_cnt != 8'hFF) begin
              r_rej_cnt <= r_rej_cnt + 1'b1;
            end
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          r_sum    <= w_sum_next;
          r_primed <= 1'b1;
          if (r_primed) begin
            r_ptr <= r_ptr + 1'b1;
          end
          r_state <= ST_DIVIDE;
        end
        ST_DIVIDE: begin
          if (w_div_done) begin
            r_state <= ST_OUT;
          end
        end
        ST_OUT: begin
          r_dist_cm    <= w_dist_new;
          r_dist_valid <= 1'b1;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef DIST_FILTER_ALARM_EN
  localparam logic [DIST_W-1:0] ON_V  = DIST_W'(ALARM_ON_CM);
  localparam logic [DIST_W-1:0] OFF_V = DIST_W'(ALARM_OFF_CM);

  logic r_alarm;

  // Hysteresis alarm, evaluated against the distance being published.
  always_ff @(posedge clk_1mhz or negedge nrst) begin
    if (!nrst) begin
      r_alarm <= 1'b0;
    end else if (r_state == ST_OUT) begin
      if (w_dist_new < ON_V) begin
        r_alarm <= 1'b1;
      end else if (w_dist_new >= OFF_V) begin
        r_alarm <= 1'b0;
      end
    end
  end

  assign alarm = r_alarm;
`else
  assign alarm = 1'b0;
`endif

  assign dist_cm    = r_dist_cm;
  assign dist_valid = r_dist_valid;
  assign busy       = (r_state != ST_IDLE);
  assign rej_cnt    = r_rej_cnt;

endmodule

// File: tb/tb_dist_filter.sv
// ---------------------------------------------------------------------------
// tb_dist_filter
// Self-checking bench for dist_filter. A queue-based moving-average model
// predicts distance, alarm and reject count for every measurement sent.
// ---------------------------------------------------------------------------
module tb_dist_filter;

  localparam int DEPTH  = 4;
  localparam int MIN_US = 116;
  localparam int MAX_US = 23200;
  localparam int ON_CM  = 20;
  localparam int OFF_CM = 25;
  localparam int LAT    = 19;

  logic        clk_1mhz = 1'b0;
  logic        nrst = 1'b0;
  logic        meas_valid = 1'b0;
  logic [15:0] meas_us = 16'd0;
  logic        meas_ovf = 1'b0;
  logic [9:0]  dist_cm;
  logic        dist_valid;
  logic        busy;
  logic        alarm;
  logic [7:0]  rej_cnt;

  int total = 0;
  int bad = 0;

  int mRing[$];
  bit mPrimed;
  int mDist;
  bit mAlarm;
  int mRej;

  dist_filter dut (
    .clk_1mhz   (clk_1mhz),
    .nrst       (nrst),
    .meas_valid (meas_valid),
    .meas_us    (meas_us),
    .meas_ovf   (meas_ovf),
    .dist_cm    (dist_cm),
    .dist_valid (dist_valid),
    .busy       (busy),
    .alarm      (alarm),
    .rej_cnt    (rej_cnt)
  );

  always #5 clk_1mhz = ~clk_1mhz;

  // Reference model: average of the last DEPTH accepted samples, in cm.
  task automatic model_reset();
    mRing.delete();
    mPrimed = 0;
    mDist = 0;
    mAlarm = 0;
    mRej = 0;
  endtask

  task automatic model_apply(input int us, input bit ovf, output bit acc);
    int sum;
    int q;
    acc = !ovf && (us >= MIN_US) && (us <= MAX_US);
    if (!acc) begin
      if (mRej < 255) mRej++;
    end else begin
      if (!mPrimed) begin
        mRing.delete();
        repeat (DEPTH) mRing.push_back(us);
        mPrimed = 1;
      end else begin
        void'(mRing.pop_front());
        mRing.push_back(us);
      end
      sum = 0;
      foreach (mRing[i]) sum += mRing[i];
      q = (sum / DEPTH) / 58;
      if (q > 1023) q = 1023;
      mDist = q;
`ifdef DIST_FILTER_ALARM_EN
      if (q < ON_CM) mAlarm = 1;
      else if (q >= OFF_CM) mAlarm = 0;
`endif
    end
  endtask

  task automatic do_reset();
    @(negedge clk_1mhz);
    nrst = 1'b0;
    repeat (2) @(negedge clk_1mhz);
    nrst = 1'b1;
    @(negedge clk_1mhz);
    model_reset();
  endtask

  // Send one measurement and watch a bounded 32-cycle window; n counts edges
  // after the edge that sampled meas_valid. Optionally inject a second strobe
  // or a reset inside the window.
  task automatic applyStimulus(input int us, input bit ovf, input int secondAt, input int resetAt,
                               output int pulses, output int lat, output int cm,
                               output bit al, output bit busyMid);
    pulses = 0; lat = -1; cm = -1; al = 0; busyMid = 0;
    @(negedge clk_1mhz);
    meas_us = us[15:0];
    meas_ovf = ovf;
    meas_valid = 1'b1;
    @(negedge clk_1mhz);
    meas_valid = 1'b0;
    meas_ovf = 1'b0;
    for (int n = 0; n < 32; n++) begin
      if (dist_valid) begin
        pulses++;
        if (lat < 0) begin
          lat = n; cm = dist_cm; al = alarm;
        end
      end
      if (n == 4) busyMid = busy;
      meas_valid = (n == secondAt);
      if (n == secondAt) meas_us = 16'd5000;
      if (n == resetAt) nrst = 1'b0;
      if (n == resetAt + 2) nrst = 1'b1;
      @(negedge clk_1mhz);
    end
    meas_valid = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (3) @(negedge clk_1mhz);
    total += 5;
    if (dist_cm !== 10'd0) begin bad++; $display("[TB] FAIL rst_dist: got %0d expected 0", dist_cm); end
    if (dist_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid: got %0b expected 0", dist_valid); end
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy: got %0b expected 0", busy); end
    if (alarm !== 1'b0) begin bad++; $display("[TB] FAIL rst_alarm: got %0b expected 0", alarm); end
    if (rej_cnt !== 8'd0) begin bad++; $display("[TB] FAIL rst_rej: got %0d expected 0", rej_cnt); end
    nrst = 1'b1;
    repeat (2) @(negedge clk_1mhz);
    model_reset();
    total++;
    if (busy !== 1'b0 || dist_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL rst_release: busy=%0b valid=%0b expected 0 0", busy, dist_valid);
    end
  endtask

  // Checks one accepted/rejected sample against the model.
  task automatic test_sample(input string tag, input int us, input bit ovf);
    int p, l, c; bit a, b, acc;
    int prevDist;
    prevDist = mDist;
    model_apply(us, ovf, acc);
    applyStimulus(us, ovf, -1, -1, p, l, c, a, b);
    total += 2;
    if (p !== (acc ? 1 : 0)) begin bad++; $display("[TB] FAIL %s_pulses: got %0d expected %0d", tag, p, acc ? 1 : 0); end
    if (rej_cnt !== mRej[7:0]) begin bad++; $display("[TB] FAIL %s_rej: got %0d expected %0d", tag, rej_cnt, mRej); end
    if (acc) begin
      total += 3;
      if (l !== LAT) begin bad++; $display("[TB] FAIL %s_lat: got %0d expected %0d", tag, l, LAT); end
      if (c !== mDist) begin bad++; $display("[TB] FAIL %s_dist: got %0d expected %0d", tag, c, mDist); end
      if (a !== mAlarm) begin bad++; $display("[TB] FAIL %s_alarm: got %0b expected %0b", tag, a, mAlarm); end
    end else begin
      total++;
      if (dist_cm !== prevDist[9:0]) begin bad++; $display("[TB] FAIL %s_hold: got %0d expected %0d", tag, dist_cm, prevDist); end
    end
  endtask

  task automatic test_priming();
    test_sample("prime", 1160, 1'b0);
    total++;
    if (dist_cm !== 10'd20) begin bad++; $display("[TB] FAIL prime_20: got %0d expected 20", dist_cm); end
  endtask

  task automatic test_averaging();
    for (int i = 0; i < 4; i++) test_sample("avg", 2320, 1'b0);
    total++;
    if (dist_cm !== 10'd40) begin bad++; $display("[TB] FAIL avg_final: got %0d expected 40", dist_cm); end
  endtask

  task automatic test_reject();
    test_sample("rej_ovf", 1160, 1'b1);
    test_sample("rej_low", 50, 1'b0);
    test_sample("rej_high", 30000, 1'b0);
    test_sample("rej_min1", MIN_US - 1, 1'b0);
    test_sample("rej_max1", MAX_US + 1, 1'b0);
    test_sample("acc_min", MIN_US, 1'b0);
    test_sample("acc_max", MAX_US, 1'b0);
  endtask

  task automatic test_busy_drop();
    int p, l, c; bit a, b, acc;
    model_apply(3480, 1'b0, acc);
    applyStimulus(3480, 1'b0, 4, -1, p, l, c, a, b);
    total += 5;
    if (p !== 1) begin bad++; $display("[TB] FAIL busy_pulses: got %0d expected 1", p); end
    if (l !== LAT) begin bad++; $display("[TB] FAIL busy_lat: got %0d expected %0d", l, LAT); end
    if (c !== mDist) begin bad++; $display("[TB] FAIL busy_dist: got %0d expected %0d", c, mDist); end
    if (b !== 1'b1) begin bad++; $display("[TB] FAIL busy_flag: got %0b expected 1", b); end
    if (rej_cnt !== mRej[7:0]) begin bad++; $display("[TB] FAIL busy_rej: got %0d expected %0d", rej_cnt, mRej); end
  endtask

  task automatic test_hysteresis();
    int targets[5] = '{22, 24, 25, 21, 19};
    do_reset();
    test_sample("hys_prime", 19 * 58, 1'b0);
    foreach (targets[t]) begin
      for (int k = 0; k < 4; k++) test_sample("hys", targets[t] * 58, 1'b0);
    end
  endtask

  task automatic test_random();
    int us; bit ovf; int kind;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 5);
      ovf = 1'b0;
      if (kind == 0) begin
        ovf = 1'b1; us = $urandom_range(MIN_US, MAX_US);
      end else if (kind == 1) begin
        us = ($urandom_range(0, 1) == 0) ? $urandom_range(0, MIN_US - 1) : $urandom_range(MAX_US + 1, 65535);
      end else begin
        us = $urandom_range(MIN_US, MAX_US);
      end
      test_sample("rand", us, ovf);
    end
  endtask

  task automatic test_reset_mid_divide();
    int p, l, c; bit a, b;
    applyStimulus(2320, 1'b0, -1, 10, p, l, c, a, b);
    model_reset();
    total += 6;
    if (p !== 0) begin bad++; $display("[TB] FAIL mid_pulses: got %0d expected 0", p); end
    if (dist_cm !== 10'd0) begin bad++; $display("[TB] FAIL mid_dist: got %0d expected 0", dist_cm); end
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_busy: got %0b expected 0", busy); end
    if (alarm !== 1'b0) begin bad++; $display("[TB] FAIL mid_alarm: got %0b expected 0", alarm); end
    if (rej_cnt !== 8'd0) begin bad++; $display("[TB] FAIL mid_rej: got %0d expected 0", rej_cnt); end
    if (dist_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_valid: got %0b expected 0", dist_valid); end
    test_sample("reprime", 580, 1'b0);
    total++;
    if (dist_cm !== 10'd10) begin bad++; $display("[TB] FAIL reprime_10: got %0d expected 10", dist_cm); end
  endtask

  task automatic test_saturation();
    bit acc;
    int seen;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_1mhz);
      meas_us = 16'd1000; meas_ovf = 1'b1; meas_valid = 1'b1;
      @(negedge clk_1mhz);
      meas_valid = 1'b0; meas_ovf = 1'b0;
      if (dist_valid) seen++;
      @(negedge clk_1mhz);
      if (dist_valid) seen++;
      model_apply(1000, 1'b1, acc);
    end
    repeat (3) @(negedge clk_1mhz);
    total += 3;
    if (rej_cnt !== mRej[7:0]) begin bad++; $display("[TB] FAIL sat_rej: got %0d expected %0d", rej_cnt, mRej); end
    if (rej_cnt !== 8'd255) begin bad++; $display("[TB] FAIL sat_255: got %0d expected 255", rej_cnt); end
    if (seen !== 0) begin bad++; $display("[TB] FAIL sat_pulses: got %0d expected 0", seen); end
  endtask

  task automatic checkOutput();
    $display("test done: total=%0d bad=%0d", total, bad);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_priming();
    test_averaging();
    test_reject();
    test_busy_drop();
    test_hysteresis();
    test_random();
    test_reset_mid_divide();
    test_saturation();
    checkOutput();
    $finish;
  end

endmodule
